// File: rtl/seq_divider_16bit_pkg.sv
// Shared types and constants for the 16-bit sequential signed divider.
package seq_divider_16bit_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   localparam int          ITER_COUNT = 16;
   localparam logic [15:0] SAT_POS    = 16'h7FFF;
   localparam logic [15:0] SAT_NEG    = 16'h8000;
   localparam logic [3:0]  CNT_LAST   = 4'(ITER_COUNT - 1);

endpackage

// File: rtl/seq_divider_16bit_div_step.sv
// One restoring division step: shift in the next dividend bit, compare, subtract.
module seq_divider_16bit_div_step (
   input  logic [15:0] rem_i,
   input  logic        bit_i,
   input  logic [16:0] dvs_i,
   output logic [15:0] rem_o,
   output logic        q_o
);

   logic [16:0] shifted;
   logic [15:0] diff;

   // The partial remainder is always below |divisor| <= 2^15, so 16 bits hold it
   // and the difference never needs bit 16.
   assign shifted = {rem_i, bit_i};
   assign q_o     = (shifted >= dvs_i);
   assign diff    = shifted[15:0] - dvs_i[15:0];
   assign rem_o   = q_o ? diff : shifted[15:0];

endmodule

// File: rtl/seq_divider_16bit.sv
// 16-bit signed sequential divider: restoring shift-subtract on magnitudes, signs
// and saturation applied in a final fix-up cycle.
//   state  | meaning
//   S_IDLE | waiting for start; operands captured on acceptance
//   S_CALC | one shift-subtract step per cycle, 16 cycles
//   S_FIX  | apply signs / saturation, register results, pulse done
module seq_divider_16bit
   import seq_divider_16bit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [15:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [15:0] quotient,
   output logic [15:0] remainder,
   output logic        ovfl,
   output logic        div_by_zero
);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] dvd_q, dvd_d;
   logic [16:0] dvs_q, dvs_d;
   logic [15:0] rem_q, rem_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        dz_q, dz_d;
   logic [15:0] quo_q, quo_d;
   logic [15:0] rmd_q, rmd_d;
   logic        ovfl_q, ovfl_d;
   logic        dzo_q, dzo_d;
   logic        done_q, done_d;

   logic [15:0] step_rem;
   logic        step_q;
   logic [15:0] rmag;
   logic [15:0] fix_quo;
   logic [15:0] fix_rmd;
   logic        fix_ovfl;

   seq_divider_16bit_div_step u_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[15]),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   // After CALC, dvd_q holds |quotient|; on divide-by-zero it still holds |dividend|.
   always_comb begin
      rmag     = dz_q ? dvd_q : rem_q;
      fix_rmd  = rneg_q ? 16'(-rmag) : rmag;
      fix_quo  = dvd_q;
      fix_ovfl = 1'b0;
      if (dz_q) begin
         fix_quo  = rneg_q ? SAT_NEG : SAT_POS;
         fix_ovfl = 1'b1;
      end else if (qneg_q) begin
         fix_quo = 16'(-dvd_q);
      end else if (dvd_q[15]) begin
         fix_quo  = SAT_POS;
         fix_ovfl = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      ovfl_d  = ovfl_q;
      dzo_d   = dzo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !done_q) begin
               dvd_d   = dividend[15] ? 16'(-dividend) : dividend;
               dvs_d   = {1'b0, (divisor[15] ? 16'(-divisor) : divisor)};
               rem_d   = '0;
               cnt_d   = '0;
               qneg_d  = dividend[15] ^ divisor[15];
               rneg_d  = dividend[15];
               dz_d    = (divisor == '0);
               state_d = (divisor == '0) ? S_FIX : S_CALC;
            end
         end
         S_CALC: begin
            dvd_d = {dvd_q[14:0], step_q};
            rem_d = step_rem;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) state_d = S_FIX;
         end
         S_FIX: begin
            quo_d   = fix_quo;
            rmd_d   = fix_rmd;
            ovfl_d  = fix_ovfl;
            dzo_d   = dz_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         ovfl_q  <= 1'b0;
         dzo_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         ovfl_q  <= ovfl_d;
         dzo_q   <= dzo_d;
         done_q  <= done_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign ovfl        = ovfl_q;
   assign div_by_zero = dzo_q;

endmodule
